// File: rtl/corr_preamble_gen_if.sv
// Sample-in / correlation-out bundle for the es8psk preamble correlator.
// in_valid qualifies sig_i/sig_q for one cycle and there is no backpressure; corr_valid qualifies corr the same way.
interface corr_preamble_gen_if #(
    parameter int W_IN  = 16,
    parameter int W_ACC = 22
);
    logic                    in_valid;
    logic signed [W_IN-1:0]  sig_i;
    logic signed [W_IN-1:0]  sig_q;
    logic                    clear;
    logic        [W_ACC-1:0] threshold;
    logic                    corr_valid;
    logic        [W_ACC-1:0] corr;
    logic                    peak_strobe;
    logic        [W_ACC-1:0] peak_mag;
    logic        [1:0]       state_dbg;

    modport master (
        output in_valid, sig_i, sig_q, clear, threshold,
        input  corr_valid, corr, peak_strobe, peak_mag, state_dbg
    );

    modport slave (
        input  in_valid, sig_i, sig_q, clear, threshold,
        output corr_valid, corr, peak_strobe, peak_mag, state_dbg
    );
endinterface

// File: rtl/corr_preamble_gen.sv
// Sliding-window I/Q preamble correlator with alpha-max-beta-min magnitude
// and a threshold / peak-search FSM producing one strobe per preamble.
module corr_preamble_gen #(
    parameter int           W_IN     = 16,
    parameter int           N        = 5,
    parameter int           L        = 10,
    parameter logic [L-1:0] MASK     = 10'b1010000101,
    parameter logic [L-1:0] PATTERN  = 10'b1111111111,
    parameter int           PEAK_WIN = 8,
    parameter int           HOLDOFF  = 40
) (
    input  logic               clk,
    input  logic               reset_b,
    corr_preamble_gen_if.slave bus
);
    localparam int NL     = N * L;
    localparam int W_ACC  = W_IN + $clog2(NL);
    localparam int W_CNT  = $clog2(PEAK_WIN + 1);
    localparam int W_HCNT = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, HOLD = 2'd2} state_t;

    logic signed [W_IN-1:0] dl_i_q [1:NL];
    logic signed [W_IN-1:0] dl_i_d [1:NL];
    logic signed [W_IN-1:0] dl_q_q [1:NL];
    logic signed [W_IN-1:0] dl_q_d [1:NL];
    logic signed [W_IN-1:0] tap_i [0:NL];
    logic signed [W_IN-1:0] tap_q [0:NL];

    always_comb begin
        tap_i[0] = bus.sig_i;
        tap_q[0] = bus.sig_q;
        for (int j = 1; j <= NL; j++) begin
            tap_i[j] = dl_i_q[j];
            tap_q[j] = dl_q_q[j];
        end
    end

    always_comb begin
        dl_i_d = dl_i_q;
        dl_q_d = dl_q_q;
        for (int j = 1; j <= NL; j++) begin
            if (bus.clear) begin
                dl_i_d[j] = '0;
                dl_q_d[j] = '0;
            end else if (bus.in_valid) begin
                dl_i_d[j] = tap_i[j-1];
                dl_q_d[j] = tap_q[j-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int j = 1; j <= NL; j++) begin
                dl_i_q[j] <= '0;
                dl_q_q[j] <= '0;
            end
        end else begin
            dl_i_q <= dl_i_d;
            dl_q_q <= dl_q_d;
        end
    end

    // Each window accumulator is the running sum of its N taps: add the sample entering, drop the one leaving.
    logic signed [W_ACC-1:0] acc_i [L];
    logic signed [W_ACC-1:0] acc_q [L];

    for (genvar k = 0; k < L; k++) begin : g_acc
        if (MASK[k]) begin : g_on
            logic signed [W_ACC-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
            always_comb begin
                acc_i_d = acc_i_q;
                acc_q_d = acc_q_q;
                if (bus.clear) begin
                    acc_i_d = '0;
                    acc_q_d = '0;
                end else if (bus.in_valid) begin
                    acc_i_d = acc_i_q + W_ACC'(tap_i[k*N]) - W_ACC'(tap_i[k*N+N]);
                    acc_q_d = acc_q_q + W_ACC'(tap_q[k*N]) - W_ACC'(tap_q[k*N+N]);
                end
            end
            always_ff @(posedge clk or negedge reset_b) begin
                if (!reset_b) begin
                    acc_i_q <= '0;
                    acc_q_q <= '0;
                end else begin
                    acc_i_q <= acc_i_d;
                    acc_q_q <= acc_q_d;
                end
            end
            assign acc_i[k] = acc_i_q;
            assign acc_q[k] = acc_q_q;
        end else begin : g_off
            assign acc_i[k] = '0;
            assign acc_q[k] = '0;
        end
    end

    logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [W_ACC-1:0] sum_i_q, sum_i_d, sum_q_q, sum_q_d;
    logic        [W_ACC-1:0] abs_i, abs_q, mag_hi, mag_lo;
    logic        [W_ACC-1:0] corr_q, corr_d;

    always_comb begin
        v1_d = bus.in_valid & ~bus.clear;
        v2_d = v1_q & ~bus.clear;
        v3_d = v2_q & ~bus.clear;
        sum_i_d = sum_i_q;
        sum_q_d = sum_q_q;
        if (bus.clear) begin
            sum_i_d = '0;
            sum_q_d = '0;
        end else if (v1_q) begin
            sum_i_d = '0;
            sum_q_d = '0;
            for (int k = 0; k < L; k++) begin
                if (PATTERN[k]) begin
                    sum_i_d = sum_i_d + acc_i[k];
                    sum_q_d = sum_q_d + acc_q[k];
                end else begin
                    sum_i_d = sum_i_d - acc_i[k];
                    sum_q_d = sum_q_d - acc_q[k];
                end
            end
        end
    end

    // max + min/2 never exceeds 1.5x the largest reachable |sum|, so W_ACC unsigned is enough.
    always_comb begin
        abs_i  = sum_i_q[W_ACC-1] ? $unsigned(-sum_i_q) : $unsigned(sum_i_q);
        abs_q  = sum_q_q[W_ACC-1] ? $unsigned(-sum_q_q) : $unsigned(sum_q_q);
        mag_hi = (abs_i > abs_q) ? abs_i : abs_q;
        mag_lo = (abs_i > abs_q) ? abs_q : abs_i;
        corr_d = corr_q;
        if (bus.clear) begin
            corr_d = '0;
        end else if (v2_q) begin
            corr_d = mag_hi + (mag_lo >> 1);
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            sum_i_q <= '0;
            sum_q_q <= '0;
            corr_q  <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            sum_i_q <= sum_i_d;
            sum_q_q <= sum_q_d;
            corr_q  <= corr_d;
        end
    end

    state_t              state_q, state_d;
    logic [W_ACC-1:0]    max_q, max_d, pmag_q, pmag_d;
    logic [W_CNT-1:0]    cnt_q, cnt_d;
    logic [W_HCNT-1:0]   hcnt_q, hcnt_d;
    logic                strobe_q, strobe_d;

    // Equal samples count as "no new maximum", so the earliest of tied peaks is kept.
    always_comb begin
        state_d  = state_q;
        max_d    = max_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        pmag_d   = pmag_q;
        strobe_d = 1'b0;
        if (bus.clear) begin
            state_d = SEARCH;
            max_d   = '0;
            cnt_d   = '0;
            hcnt_d  = '0;
            pmag_d  = '0;
        end else if (v3_q) begin
            unique case (state_q)
                SEARCH: begin
                    if (corr_q >= bus.threshold) begin
                        max_d   = corr_q;
                        cnt_d   = '0;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (corr_q > max_q) begin
                        max_d = corr_q;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == W_CNT'(PEAK_WIN)) begin
                            strobe_d = 1'b1;
                            pmag_d   = max_q;
                            hcnt_d   = '0;
                            state_d  = HOLD;
                        end
                    end
                end
                HOLD: begin
                    hcnt_d = hcnt_q + 1'b1;
                    if (hcnt_d == W_HCNT'(HOLDOFF)) state_d = SEARCH;
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= SEARCH;
            max_q    <= '0;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            pmag_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            max_q    <= max_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            pmag_q   <= pmag_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.corr_valid  = v3_q;
    assign bus.corr        = corr_q;
    assign bus.peak_strobe = strobe_q;
    assign bus.peak_mag    = pmag_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_corr_preamble_gen.sv
// Bench for corr_preamble_gen: two instances (all-positive pattern and symbol 2 negated)
// share one stimulus stream and are checked against a windowed-sum reference model.
module tb_corr_preamble_gen;
    localparam int           W_IN     = 16;
    localparam int           N        = 5;
    localparam int           L        = 10;
    localparam int           NL       = N * L;
    localparam int           W_ACC    = 22;
    localparam int           PEAK_WIN = 8;
    localparam int           HOLDOFF  = 40;
    localparam logic [L-1:0] MASK     = 10'b1010000101;
    localparam logic [L-1:0] PAT_A    = 10'b1111111111;
    localparam logic [L-1:0] PAT_B    = 10'b1111111011;

    logic clk = 1'b0;
    logic reset_b = 1'b1;
    always #5 clk = ~clk;

    logic drv_valid, drv_clear;
    int   drv_i, drv_q, drv_thr;

    corr_preamble_gen_if #(.W_IN(W_IN), .W_ACC(W_ACC)) bus_a ();
    corr_preamble_gen_if #(.W_IN(W_IN), .W_ACC(W_ACC)) bus_b ();

    assign bus_a.in_valid  = drv_valid;
    assign bus_a.sig_i     = drv_i[W_IN-1:0];
    assign bus_a.sig_q     = drv_q[W_IN-1:0];
    assign bus_a.clear     = drv_clear;
    assign bus_a.threshold = drv_thr[W_ACC-1:0];
    assign bus_b.in_valid  = drv_valid;
    assign bus_b.sig_i     = drv_i[W_IN-1:0];
    assign bus_b.sig_q     = drv_q[W_IN-1:0];
    assign bus_b.clear     = drv_clear;
    assign bus_b.threshold = drv_thr[W_ACC-1:0];

    corr_preamble_gen #(.W_IN(W_IN), .N(N), .L(L), .MASK(MASK), .PATTERN(PAT_A),
                        .PEAK_WIN(PEAK_WIN), .HOLDOFF(HOLDOFF))
        dut_a (.clk(clk), .reset_b(reset_b), .bus(bus_a));
    corr_preamble_gen #(.W_IN(W_IN), .N(N), .L(L), .MASK(MASK), .PATTERN(PAT_B),
                        .PEAK_WIN(PEAK_WIN), .HOLDOFF(HOLDOFF))
        dut_b (.clk(clk), .reset_b(reset_b), .bus(bus_b));

    // Reference model state: sample history (newest first), 2-deep latency queue, peak-search bookkeeping.
    int hist_i[$];
    int hist_q[$];
    bit pv0, pv1;
    int pc0[2], pc1[2];
    bit e_cv;
    int e_corr[2], e_pmag[2];
    bit e_strobe[2];
    int m_st[2], m_mx[2], m_cnt[2], m_hcnt[2];
    int total, bad;
    int strobes[2], hits100[2];

    function automatic int model_corr(input logic [L-1:0] pat);
        logic [L-1:0] msk;
        int si, sq, wi, wq, ai, aq, hi, lo;
        msk = MASK;
        si = 0;
        sq = 0;
        for (int k = 0; k < L; k++) begin
            if (msk[k]) begin
                wi = 0;
                wq = 0;
                for (int m = 0; m < N; m++) begin
                    if (k * N + m < hist_i.size()) begin
                        wi += hist_i[k*N+m];
                        wq += hist_q[k*N+m];
                    end
                end
                si += pat[k] ? wi : -wi;
                sq += pat[k] ? wq : -wq;
            end
        end
        ai = (si < 0) ? -si : si;
        aq = (sq < 0) ? -sq : sq;
        hi = (ai > aq) ? ai : aq;
        lo = (ai > aq) ? aq : ai;
        return hi + lo / 2;
    endfunction

    task automatic model_reset();
        hist_i.delete();
        hist_q.delete();
        pv0 = 0;
        pv1 = 0;
        e_cv = 0;
        for (int u = 0; u < 2; u++) begin
            pc0[u] = 0; pc1[u] = 0; e_corr[u] = 0; e_pmag[u] = 0; e_strobe[u] = 0;
            m_st[u] = 0; m_mx[u] = 0; m_cnt[u] = 0; m_hcnt[u] = 0;
        end
    endtask

    // Peak search rules: 0 = searching, 1 = tracking a maximum, 2 = ignoring samples after a peak.
    task automatic peak_rules(input int u, input int c, input int thr);
        if (m_st[u] == 0) begin
            if (c >= thr) begin
                m_mx[u] = c; m_cnt[u] = 0; m_st[u] = 1;
            end
        end else if (m_st[u] == 1) begin
            if (c > m_mx[u]) begin
                m_mx[u] = c; m_cnt[u] = 0;
            end else begin
                m_cnt[u]++;
                if (m_cnt[u] == PEAK_WIN) begin
                    e_strobe[u] = 1; e_pmag[u] = m_mx[u]; m_hcnt[u] = 0; m_st[u] = 2;
                end
            end
        end else begin
            m_hcnt[u]++;
            if (m_hcnt[u] == HOLDOFF) m_st[u] = 0;
        end
    endtask

    task automatic model_edge(input bit v, input int i, input int q, input bit clr, input int thr);
        if (clr) begin
            model_reset();
            return;
        end
        for (int u = 0; u < 2; u++) begin
            e_strobe[u] = 0;
            if (e_cv) peak_rules(u, e_corr[u], thr);
        end
        e_cv = pv1;
        for (int u = 0; u < 2; u++) if (pv1) e_corr[u] = pc1[u];
        pv1 = pv0;
        pc1 = pc0;
        pv0 = v;
        if (v) begin
            hist_i.push_front(i);
            hist_q.push_front(q);
            if (hist_i.size() > NL) begin
                void'(hist_i.pop_back());
                void'(hist_q.pop_back());
            end
            pc0[0] = model_corr(PAT_A);
            pc0[1] = model_corr(PAT_B);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_unit(input int u, input logic cv, input logic [W_ACC-1:0] c,
                            input logic ps, input logic [W_ACC-1:0] pm);
        chk($sformatf("corr_valid_%0d", u), 64'(cv), 64'(e_cv));
        chk($sformatf("corr_%0d", u), 64'(c), 64'(e_corr[u]));
        chk($sformatf("peak_strobe_%0d", u), 64'(ps), 64'(e_strobe[u]));
        chk($sformatf("peak_mag_%0d", u), 64'(pm), 64'(e_pmag[u]));
        if (ps === 1'b1) strobes[u]++;
        if (cv === 1'b1 && c == 100) hits100[u]++;
    endtask

    task automatic check_both();
        chk_unit(0, bus_a.corr_valid, bus_a.corr, bus_a.peak_strobe, bus_a.peak_mag);
        chk_unit(1, bus_b.corr_valid, bus_b.corr, bus_b.peak_strobe, bus_b.peak_mag);
    endtask

    // Called at a falling edge; inputs are sampled at the next rising edge and outputs checked one falling edge later.
    task automatic step(input bit v, input int i, input int q, input bit clr);
        drv_valid = v;
        drv_i     = i;
        drv_q     = q;
        drv_clear = clr;
        @(posedge clk);
        @(negedge clk);
        model_edge(v, i, q, clr, drv_thr);
        check_both();
    endtask

    task automatic burst(input int n, input int i, input int q, input bit gapped);
        for (int s = 0; s < n; s++) begin
            step(1, i, q, 0);
            if (gapped) step(0, 0, 0, 0);
        end
    endtask

    task automatic idle(input int n);
        for (int s = 0; s < n; s++) step(0, 0, 0, 0);
    endtask

    task automatic do_clear();
        step(0, 0, 0, 1);
        strobes[0] = 0; strobes[1] = 0; hits100[0] = 0; hits100[1] = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        drv_valid = 0; drv_clear = 0; drv_i = 0; drv_q = 0;
        drv_thr = 4194303;
        model_reset();
        strobes[0] = 0; strobes[1] = 0; hits100[0] = 0; hits100[1] = 0;
        #2 reset_b = 1'b0;
        repeat (2) @(negedge clk);
        check_both();
        reset_b = 1'b1;

        // Constant tones: ramp of 1000 per sample settling at full-preamble value.
        burst(60, 1000, 0, 0);
        idle(3);
        chk("ramp_hold_i", 64'(bus_a.corr), 64'd20000);
        do_clear();
        burst(60, 0, 1000, 0);
        idle(3);
        chk("ramp_hold_q", 64'(bus_a.corr), 64'd20000);
        do_clear();
        burst(60, 1000, 1000, 0);
        idle(3);
        chk("ramp_hold_iq", 64'(bus_a.corr), 64'd30000);

        // Asynchronous reset between clock edges, then first-sample latency.
        burst(7, 500, -300, 0);
        reset_b = 1'b0;
        #1;
        model_reset();
        check_both();
        #1 reset_b = 1'b1;
        step(1, 400, 0, 0);
        idle(2);
        chk("rst_latency", 64'(bus_a.corr_valid), 64'd1);

        // Single impulse visits the 20 masked tap positions.
        do_clear();
        step(1, 100, 0, 0);
        burst(70, 0, 0, 0);
        idle(3);
        chk("impulse_hits_a", 64'(hits100[0]), 64'd20);
        chk("impulse_hits_b", 64'(hits100[1]), 64'd20);

        // Two impulses ten apart land in windows 2 and 0 together.
        do_clear();
        step(1, 100, 0, 0);
        burst(9, 0, 0, 0);
        step(1, 100, 0, 0);
        burst(2, 0, 0, 0);
        chk("two_imp_a", 64'(bus_a.corr), 64'd200);
        chk("two_imp_b", 64'(bus_b.corr), 64'd0);
        burst(58, 0, 0, 0);

        // Peak detection on a tone burst, continuous and gapped.
        do_clear();
        drv_thr = 15000;
        burst(50, 1000, 0, 0);
        burst(100, 0, 0, 0);
        chk("peak_count", 64'(strobes[0]), 64'd1);
        chk("peak_value", 64'(bus_a.peak_mag), 64'd20000);
        do_clear();
        burst(50, 1000, 0, 1);
        burst(100, 0, 0, 1);
        chk("gap_peak_count", 64'(strobes[0]), 64'd1);
        chk("gap_peak_value", 64'(bus_a.peak_mag), 64'd20000);

        // Flush while tracking, then a fresh burst.
        do_clear();
        burst(45, 1000, 0, 0);
        do_clear();
        chk("clear_state", 64'(bus_a.state_dbg), 64'd0);
        burst(30, 0, 0, 0);
        chk("clear_no_peak", 64'(strobes[0]), 64'd0);
        burst(50, 1000, 0, 0);
        burst(100, 0, 0, 0);
        chk("after_clear_peak", 64'(strobes[0]), 64'd1);

        // Random traffic with gaps, occasional flushes and threshold changes.
        do_clear();
        for (int s = 0; s < 800; s++) begin
            bit v, clr;
            int ri, rq;
            if (s % 100 == 0) drv_thr = int'($urandom_range(2000, 40000));
            v   = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 3) == 0) begin
                ri = int'($urandom_range(0, 65535)) - 32768;
                rq = int'($urandom_range(0, 65535)) - 32768;
            end else begin
                ri = int'($urandom_range(0, 6000)) - 3000;
                rq = int'($urandom_range(0, 6000)) - 3000;
            end
            step(v, ri, rq, clr);
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
